// File: rtl/amem_array.sv
// A-memory storage array: 1024x32 RAM with a one-entry posted write buffer and read forwarding.
// Define AMEM_CLEAR_EN to zero the array with a power-up clear sequence after reset.
module amem_array #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] aadr,
  input  logic          arp,
  input  logic          awp,
  input  logic [DW-1:0] l,
  output logic [DW-1:0] a,
  output logic          ready
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic          r_wbuf_valid;
  logic [AW-1:0] r_wbuf_adr;
  logic [DW-1:0] r_wbuf_data;
  logic [DW-1:0] r_a;
  logic          r_ready;

  logic          w_run;
  logic          w_ready_nxt;
  logic          w_we;
  logic [AW-1:0] w_wadr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;

`ifdef AMEM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          w_clr_last;

  assign w_clr_last = (r_clr_cnt == AW'(DEPTH - 1));

  // State register and clear address counter; the counter parks on the last address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR && !w_clr_last) begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
      ST_RUN:   w_run = 1'b1;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  assign w_ready_nxt = (w_state_nxt == ST_RUN);
`else
  assign w_run       = 1'b1;
  assign w_ready_nxt = 1'b1;
`endif

  // Single write port: clear sequencer owns it during CLEAR, write buffer drains otherwise
  always_comb begin
    w_we    = r_wbuf_valid & w_run;
    w_wadr  = r_wbuf_adr;
    w_wdata = r_wbuf_data;
`ifdef AMEM_CLEAR_EN
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_wadr  = r_clr_cnt;
      w_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset && w_we) begin
      r_mem[w_wadr] <= w_wdata;
    end
  end

  // Read source: same-cycle write data, then the uncommitted buffer entry, then the array
  always_comb begin
    if (awp) begin
      w_rdata = l;
    end else if (r_wbuf_valid && (r_wbuf_adr == aadr)) begin
      w_rdata = r_wbuf_data;
    end else begin
      w_rdata = r_mem[aadr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_ready      <= 1'b0;
      r_wbuf_valid <= 1'b0;
      r_wbuf_adr   <= '0;
      r_wbuf_data  <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      if (w_run) begin
        r_wbuf_valid <= awp;
        if (awp) begin
          r_wbuf_adr  <= aadr;
          r_wbuf_data <= l;
        end
        if (arp) begin
          r_a <= w_rdata;
        end
      end
    end
  end

  assign a     = r_a;
  assign ready = r_ready;

endmodule

// File: tb/tb_amem_array.sv
// Directed bench for amem_array; a "last value written" array model is checked every cycle.
module tb_amem_array;

`ifdef AMEM_CLEAR_EN
  localparam int CLR = 1024;
`else
  localparam int CLR = 0;
`endif
  localparam int READY_LAT = (CLR > 0) ? CLR : 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  aadr = '0;
  logic        arp = 1'b0;
  logic        awp = 1'b0;
  logic [31:0] l = '0;
  logic [31:0] a;
  logic        ready;

  int checks = 0;
  int errors = 0;

  amem_array #(.AW(10), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .aadr  (aadr),
    .arp   (arp),
    .awp   (awp),
    .l     (l),
    .a     (a),
    .ready (ready)
  );

  always #5 clk = ~clk;

  // Model: every word holds the last value written to it; a read sees writes of its own cycle
  logic [31:0] m_mem   [1024];
  bit          m_known [1024];
  logic [31:0] exp_a = '0;
  bit          a_known = 1'b0;
  bit          exp_ready = 1'b0;
  bit          started = 1'b0;
  bit          pend_v = 1'b0;
  logic [9:0]  pend_adr = '0;
  int          cnt = 0;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      cnt = 0;
      exp_ready = 1'b0;
      exp_a = '0;
      a_known = 1'b1;
      if (CLR > 0) begin
        for (int i = 0; i < 1024; i++) begin
          m_mem[i] = '0;
          m_known[i] = 1'b1;
        end
      end else if (pend_v) begin
        m_known[pend_adr] = 1'b0;
      end
      pend_v = 1'b0;
    end else begin
      if (cnt >= CLR) begin
        if (arp) begin
          if (awp) begin
            exp_a = l;
            a_known = 1'b1;
          end else begin
            exp_a = m_mem[aadr];
            a_known = m_known[aadr];
          end
        end
        pend_v = awp;
        if (awp) begin
          m_mem[aadr] = l;
          m_known[aadr] = 1'b1;
          pend_adr = aadr;
        end
      end else begin
        pend_v = 1'b0;
      end
      if (cnt < 100000) cnt++;
      exp_ready = (cnt >= READY_LAT);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (ready !== exp_ready) begin
        errors++;
        $display("FAIL ready_model t=%0t got %b want %b", $time, ready, exp_ready);
      end
      if (a_known) begin
        checks++;
        if (a !== exp_a) begin
          errors++;
          $display("FAIL a_model t=%0t got %h want %h", $time, a, exp_a);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op(input bit rd, input bit wr, input logic [9:0] adr, input logic [31:0] d);
    arp = rd;
    awp = wr;
    aadr = adr;
    l = d;
    tick(1);
    arp = 1'b0;
    awp = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (n < 3000) begin
      tick(1);
      n++;
      if (ready === 1'b1) break;
    end
    chk(name, 32'(n), 32'(READY_LAT));
  endtask

  initial begin
    tick(3);
    chk("reset_a", a, 32'h0);
    chk("reset_ready", {31'b0, ready}, 32'h0);
    reset = 1'b0;
    wait_ready("ready_latency");

    if (CLR > 0) begin
      op(1, 0, 10'h000, '0); chk("clear_000", a, 32'h0);
      op(1, 0, 10'h1FF, '0); chk("clear_1ff", a, 32'h0);
      op(1, 0, 10'h3FF, '0); chk("clear_3ff", a, 32'h0);
    end

    // basic write then read, and hold while arp low
    op(0, 1, 10'h015, 32'hDEADBEEF);
    tick(3);
    op(1, 0, 10'h015, '0);
    chk("basic_read", a, 32'hDEADBEEF);
    tick(2);
    chk("basic_hold", a, 32'hDEADBEEF);

    // forward from the write buffer, then a neighbouring address from the array
    op(0, 1, 10'h2A0, 32'h12345678);
    op(1, 0, 10'h2A0, '0);
    chk("buf_fwd", a, 32'h12345678);
    op(1, 0, 10'h2A1, '0);
    if (CLR > 0) chk("buf_neighbour", a, 32'h0);

    // simultaneous read and write
    op(1, 1, 10'h3FF, 32'hCAFEF00D);
    chk("rw_same", a, 32'hCAFEF00D);
    tick(1);
    op(1, 0, 10'h3FF, '0);
    chk("rw_later", a, 32'hCAFEF00D);

    // back-to-back writes, read immediately while the second is still buffered
    op(0, 1, 10'h001, 32'h11111111);
    op(0, 1, 10'h002, 32'h22222222);
    op(1, 0, 10'h001, '0);
    chk("b2b_first", a, 32'h11111111);
    op(1, 0, 10'h002, '0);
    chk("b2b_second", a, 32'h22222222);
    op(1, 1, 10'h002, 32'h33333333);
    op(1, 0, 10'h002, '0);
    chk("overwrite", a, 32'h33333333);

    // reset while a write is still in the buffer
    op(0, 1, 10'h010, 32'hAAAAAAAA);
    reset = 1'b1;
    tick(1);
    chk("midwr_reset_a", a, 32'h0);
    reset = 1'b0;
    wait_ready("ready_after_midwr");
    if (CLR > 0) begin
      op(1, 0, 10'h010, '0);
      chk("midwr_discard", a, 32'h0);
      op(1, 0, 10'h015, '0);
      chk("reclear_015", a, 32'h0);
    end

    // reset part-way through the clear
    if (CLR > 0) begin
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(500);
      chk("midclr_not_ready", {31'b0, ready}, 32'h0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      wait_ready("ready_after_midclr");
    end

    op(0, 1, 10'h155, 32'h0BADF00D);
    op(1, 0, 10'h155, '0);
    chk("final_fwd", a, 32'h0BADF00D);
    tick(2);
    op(1, 0, 10'h155, '0);
    chk("final_array", a, 32'h0BADF00D);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
